// File: rtl/uart_pulse_cmd_parser.sv
// uart_pulse_cmd_parser: decodes 0xAA/CMD/payload/CHK byte frames into pulse compare values and a fire trigger
// Ports: clk, rst_n (async, active low); rx_data/rx_valid incoming byte stream;
// pulse_start/pulse_end committed compare values; start_trig fire level held TRIG_LEN cycles;
// frame_ok/frame_err one-cycle result strobes; err_code last rejection cause; busy frame or trigger in progress.
module uart_pulse_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TRIG_LEN = 4,
  parameter logic [31:0] DEF_START = 32'd1000,
  parameter logic [31:0] DEF_END = 32'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] pulse_start,
  output logic [31:0] pulse_end,
  output logic        start_trig,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(TRIG_LEN + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(TRIG_LEN - 1);
  typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, CHECK} state_t;
  state_t state, state_n;
  logic [7:0] cmd, chk;
  logic [63:0] shadow;
  logic [2:0] cnt;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] tlen;
  logic is_load, is_fire, timeout, done;
  logic [2:0] err;
  assign is_load = cmd == 8'h01 || cmd == 8'h03;
  assign is_fire = cmd == 8'h02 || cmd == 8'h03;
  // a byte arriving in the expiry cycle wins over the timeout
  assign timeout = state != IDLE && !rx_valid && tcnt == T_LAST;
  assign done = state == CHECK && rx_valid;
  assign busy = state != IDLE || start_trig;
  // shadow holds start in the upper word and end in the lower word
  assign err = rx_data != chk ? 3'd1 :
               !(is_load || is_fire) ? 3'd2 :
               is_load && shadow[31:0] <= shadow[63:32] ? 3'd4 :
               is_fire && start_trig ? 3'd5 : 3'd0;
  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (rx_valid)
      case (state)
        IDLE:    state_n = rx_data == 8'hAA ? CMD : IDLE;
        CMD:     state_n = rx_data == 8'h01 || rx_data == 8'h03 ? PAYLOAD : CHECK;
        PAYLOAD: state_n = cnt == 3'd7 ? CHECK : PAYLOAD;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd <= '0;
      chk <= '0;
      shadow <= '0;
      cnt <= '0;
      tcnt <= '0;
      tlen <= '0;
      pulse_start <= DEF_START;
      pulse_end <= DEF_END;
      start_trig <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_n;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= state == IDLE || rx_valid || timeout ? '0 : tcnt + 1'b1;
      if (start_trig) begin
        tlen <= tlen - 1'b1;
        if (tlen == '0) start_trig <= 1'b0;
      end
      if (rx_valid && state == CMD) begin
        cmd <= rx_data;
        chk <= rx_data;
        cnt <= '0;
      end
      if (rx_valid && state == PAYLOAD) begin
        shadow <= {shadow[55:0], rx_data};
        chk <= chk ^ rx_data;
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        if (err == 3'd0) begin
          frame_ok <= 1'b1;
          if (is_load) begin
            pulse_start <= shadow[63:32];
            pulse_end <= shadow[31:0];
          end
          // a fire is only accepted while start_trig is low, so it never collides with the countdown
          if (is_fire) begin
            start_trig <= 1'b1;
            tlen <= L_LAST;
          end
        end else begin
          frame_err <= 1'b1;
          err_code <= err;
        end
      end
      if (timeout) begin
        frame_err <= 1'b1;
        err_code <= 3'd3;
        shadow <= '0;
      end
    end
endmodule

// File: tb/tb_uart_pulse_cmd_parser.sv
// tb_uart_pulse_cmd_parser: randomized frame stimulus checked against a frame-level reference model
module tb_uart_pulse_cmd_parser;
  localparam int TO = 200;
  localparam int TL = 4;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [31:0] pulse_start, pulse_end;
  logic start_trig, frame_ok, frame_err, busy;
  logic [2:0] err_code;
  int checks = 0, passed = 0;
  longint cyc = 0;
  longint fire_edge = -100;
  logic [31:0] m_start = 32'd1000, m_end = 32'd2000;
  logic [2:0] m_code = 3'd0;

  uart_pulse_cmd_parser #(.TIMEOUT_CYC(TO), .TRIG_LEN(TL), .DEF_START(32'd1000), .DEF_END(32'd2000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pulse_start(pulse_start), .pulse_end(pulse_end), .start_trig(start_trig),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bq_t mk(input logic [7:0] c, input logic [31:0] s, input logic [31:0] e, input logic [7:0] flip);
    bq_t f;
    logic [63:0] v;
    logic [7:0] x;
    v = {s, e};
    x = c;
    f.push_back(8'hAA);
    f.push_back(c);
    if (c == 8'h01 || c == 8'h03)
      for (int i = 7; i >= 0; i--) begin
        f.push_back(v[8*i +: 8]);
        x ^= v[8*i +: 8];
      end
    f.push_back(x ^ flip);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_start = 32'd1000;
    m_end = 32'd2000;
    m_code = 3'd0;
    fire_edge = -100;
  endtask

  task automatic run_frame(input bq_t f, input int gap_max, input string name);
    logic [7:0] x;
    logic [31:0] s, e;
    logic [2:0] exp;
    bit ld, fi;
    longint q;
    int n;
    n = f.size();
    for (int i = 0; i < n; i++) begin
      send_byte(f[i]);
      if (i < n - 1) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
    q = cyc;
    x = 8'h00;
    for (int i = 1; i < n - 1; i++) x ^= f[i];
    ld = f[1] == 8'h01 || f[1] == 8'h03;
    fi = f[1] == 8'h02 || f[1] == 8'h03;
    s = ld ? {f[2], f[3], f[4], f[5]} : 32'd0;
    e = ld ? {f[6], f[7], f[8], f[9]} : 32'd0;
    exp = x != f[n-1] ? 3'd1 : !(ld || fi) ? 3'd2 : ld && e <= s ? 3'd4 :
          fi && (q - fire_edge) >= 1 && (q - fire_edge) <= TL ? 3'd5 : 3'd0;
    if (exp == 3'd0) begin
      if (ld) begin
        m_start = s;
        m_end = e;
      end
      if (fi) begin
        fire_edge = q;
        checks++;
        if (start_trig !== 1'b1) $display("FAIL %s start_trig got %b want 1", name, start_trig);
        else passed++;
      end
    end else m_code = exp;
    checks++;
    if (frame_ok !== (exp == 3'd0) || frame_err !== (exp != 3'd0))
      $display("FAIL %s strobes ok/err got %b/%b want err %0d", name, frame_ok, frame_err, exp);
    else passed++;
    checks++;
    if (err_code !== m_code) $display("FAIL %s err_code got %0d want %0d", name, err_code, m_code);
    else passed++;
    checks++;
    if (pulse_start !== m_start || pulse_end !== m_end)
      $display("FAIL %s pulses got %0d/%0d want %0d/%0d", name, pulse_start, pulse_end, m_start, m_end);
    else passed++;
  endtask

  task automatic test_reset();
    checks++;
    if (pulse_start !== 32'd1000 || pulse_end !== 32'd2000 || start_trig !== 1'b0 || frame_ok !== 1'b0 ||
        frame_err !== 1'b0 || err_code !== 3'd0 || busy !== 1'b0)
      $display("FAIL reset_state got %0d/%0d trig %b ok %b err %b code %0d busy %b want 1000/2000 all zero",
               pulse_start, pulse_end, start_trig, frame_ok, frame_err, err_code, busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    bq_t f;
    f = '{8'hAA, 8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h00, 8'h00, 8'h07, 8'hD0, 8'h3D};
    run_frame(mk(8'h01, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00), 0, "load_a");
    run_frame(f, 0, "load_1000_2000");
    checks++;
    if (start_trig !== 1'b0) $display("FAIL load_no_trig got %b want 0", start_trig);
    else passed++;
    @(negedge clk);
    checks++;
    if (frame_ok !== 1'b0) $display("FAIL load_ok_one_cycle got %b want 0", frame_ok);
    else passed++;
  endtask

  task automatic test_fire();
    int run;
    run_frame(mk(8'h02, 0, 0, 8'h00), 0, "fire");
    run = 0;
    while (start_trig === 1'b1 && run < 20) begin
      run++;
      @(negedge clk);
    end
    checks++;
    if (run !== TL) $display("FAIL fire_width got %0d want %0d", run, TL);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_frame(mk(8'h02, 0, 0, 8'h00), 0, "fire_first");
    run_frame(mk(8'h02, 0, 0, 8'h00), 0, "fire_during_trig");
    run_frame(mk(8'h01, 32'd300, 32'd400, 8'h00), 0, "load_during_trig");
    repeat (8) @(negedge clk);
  endtask

  task automatic test_errors();
    run_frame(mk(8'h01, 32'd11, 32'd22, 8'h01), 0, "bad_chk");
    run_frame(mk(8'h01, 32'd5, 32'd5, 8'h00), 0, "range_equal");
    run_frame(mk(8'h03, 32'd9, 32'd4, 8'h00), 0, "range_lf");
    run_frame(mk(8'h7F, 0, 0, 8'h00), 0, "unknown_cmd");
  endtask

  task automatic test_idle_garbage();
    int bad;
    bad = 0;
    send_byte(8'h55);
    send_byte(8'h00);
    repeat (5) begin
      if (frame_ok !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("FAIL idle_garbage got %0d strobe/busy cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_timeout();
    int k, early;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (3) send_byte(8'h42);
    k = 0;
    while (frame_err !== 1'b1 && k < TO + 10) begin
      @(negedge clk);
      k++;
    end
    m_code = 3'd3;
    checks++;
    if (k < TO - 1 || k > TO + 1) $display("FAIL timeout_latency got %0d want %0d", k, TO);
    else passed++;
    checks++;
    if (err_code !== 3'd3 || busy !== 1'b0 || pulse_start !== m_start)
      $display("FAIL timeout_state got code %0d busy %b start %0d want 3 0 %0d", err_code, busy, pulse_start, m_start);
    else passed++;
    run_frame(mk(8'h02, 0, 0, 8'h00), 1, "fire_after_timeout");
    repeat (8) @(negedge clk);
    early = 0;
    send_byte(8'hAA);
    send_byte(8'h02);
    repeat (TO - 1) begin
      if (frame_err !== 1'b0) early++;
      @(negedge clk);
    end
    send_byte(8'h02);
    fire_edge = cyc;
    checks++;
    if (early != 0 || frame_ok !== 1'b1) $display("FAIL byte_beats_timeout got err %0d ok %b want 0 1", early, frame_ok);
    else passed++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] s, e, t;
    logic [7:0] c;
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(5, 0);
      s = $urandom;
      e = $urandom;
      if (kind == 0 || kind == 2 || kind == 4) begin
        if (e < s) begin t = s; s = e; e = t; end
        if (e == s) e = s + 1;
      end
      if (kind == 5 && e > s) begin t = s; s = e; e = t; end
      c = kind == 1 ? 8'h02 : kind == 2 ? 8'h03 : kind == 3 ? 8'($urandom_range(255, 4)) :
          kind == 5 && n[0] ? 8'h03 : 8'h01;
      run_frame(mk(c, s, e, kind == 4 ? 8'(1 << $urandom_range(7, 0)) : 8'h00), 2, "random");
      repeat ($urandom_range(6, 0)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int bad;
    run_frame(mk(8'h01, 32'd7, 32'd9, 8'h00), 0, "load_pre_reset");
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pulse_start !== 32'd1000 || pulse_end !== 32'd2000 || busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_mid_payload got %0d/%0d busy %b ok %b err %b want 1000/2000 0 0 0",
               pulse_start, pulse_end, busy, frame_ok, frame_err);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(mk(8'h02, 0, 0, 8'h00), 0, "fire_pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (start_trig !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_trig got trig %b busy %b want 0 0", start_trig, busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (frame_ok !== 1'b0 || frame_err !== 1'b0 || start_trig !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_no_strobe got %0d bad cycles want 0", bad);
    else passed++;
    run_frame(mk(8'h03, 32'd50, 32'd60, 8'h00), 1, "load_fire_after_reset");
    repeat (8) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_fire();
    test_back_to_back();
    test_errors();
    test_idle_garbage();
    test_timeout();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
